// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS-Lite core: opcodes, functs, FSM states,
// halt causes and ALU operations.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_OR,
    ALU_SLT,
    ALU_LUI
  } alu_op_e;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_SLT) || (fn == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// Combinational ALU for the multicycle core: add, sub, or, signed slt, lui, plus zero flag.
module mips_mc_alu
  import mips_mc_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = ($signed(a_i) < $signed(b_i)) ? 32'd1 : 32'd0;
      ALU_LUI: y_o = {b_i[15:0], 16'h0000};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == 32'd0);

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS-Lite core with one shared req/ack memory port, memory watchdog and sticky halt.
//  state  | meaning
//  FETCH  | request instruction at PC; on ack load IR, PC <= PC+4
//  DECODE | A/B <= rs/rt, ALUOut <= branch target, trap illegal instructions
//  EXEC   | ALU op, branch/jump resolution, load/store address + alignment check
//  MEM    | data access at ALUOut
//  WB     | write ALU result or MDR into the GPR file
//  HALT   | stopped until rst; halt_cause holds the reason
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] pc_dbg
);

  localparam logic [31:0] WD_LIMIT = MEM_TIMEOUT - 32'd1;
  localparam bit          WD_EN    = (MEM_TIMEOUT != 32'd0);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d, wd_q, wd_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] gpr_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, rs_val, rt_val, jump_pc;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : gpr_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : gpr_q[rt];
  assign jump_pc  = {pc_q[31:28], ir_q[25:0], 2'b00};

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        alu_zero;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_sext;
    case (opcode)
      OP_RTYPE: begin
        alu_b = b_q;
        if (funct == FN_SUBU)     alu_op = ALU_SUB;
        else if (funct == FN_SLT) alu_op = ALU_SLT;
      end
      OP_BEQ, OP_BNE: begin
        alu_op = ALU_SUB;
        alu_b  = b_q;
      end
      OP_ORI: begin
        alu_op = ALU_OR;
        alu_b  = imm_zext;
      end
      OP_LUI: begin
        alu_op = ALU_LUI;
        alu_b  = imm_zext;
      end
      default: ;
    endcase
  end

  mips_mc_alu u_alu (
    .op_i   (alu_op),
    .a_i    (a_q),
    .b_i    (alu_b),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  logic mem_done, wd_hit;
  assign mem_done = mem_req && mem_ack;
  // Ack beats the watchdog when both land in the same cycle.
  assign wd_hit   = WD_EN && (wd_q == WD_LIMIT) && !mem_done;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_done) state_d = ST_DECODE;
        else if (wd_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!is_legal(opcode, funct)) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE: state_d = (funct == FN_JR) ? ST_FETCH : ST_WB;
          OP_J, OP_JAL, OP_BEQ, OP_BNE: state_d = ST_FETCH;
          OP_LW, OP_SW: begin
            if (alu_y[1:0] != 2'b00) begin
              state_d = ST_HALT;
              cause_d = CAUSE_ALIGN;
            end else begin
              state_d = ST_MEM;
            end
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_done) state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
        else if (wd_hit) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      ST_FETCH: mem_req = !rst;
      ST_MEM: begin
        mem_req  = !rst;
        mem_we   = !rst && (opcode == OP_SW);
        mem_addr = alu_out_q;
      end
      default: ;
    endcase
  end

  assign mem_wdata  = b_q;
  assign halted     = (state_q == ST_HALT);
  assign halt_cause = cause_q;
  assign pc_dbg     = pc_q;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    wd_d      = '0;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_done) begin
          ir_d = mem_rdata;
          pc_d = pc_q + 32'd4;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      ST_DECODE: begin
        a_d       = rs_val;
        b_d       = rt_val;
        alu_out_d = pc_q + {imm_sext[29:0], 2'b00};
      end
      ST_EXEC: begin
        case (opcode)
          OP_BEQ: if (alu_zero) pc_d = alu_out_q;
          OP_BNE: if (!alu_zero) pc_d = alu_out_q;
          OP_J:   pc_d = jump_pc;
          OP_JAL: begin
            pc_d     = jump_pc;
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
          end
          OP_RTYPE: begin
            if (funct == FN_JR) pc_d = a_q;
            else                alu_out_d = alu_y;
          end
          default: alu_out_d = alu_y;
        endcase
      end
      ST_MEM: begin
        if (mem_done) begin
          if (opcode == OP_LW) mdr_d = mem_rdata;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      ST_WB: begin
        rf_we = 1'b1;
        if (opcode == OP_RTYPE)  rf_waddr = rd;
        else if (opcode == OP_LW) rf_wdata = mdr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      wd_q      <= '0;
      cause_q   <= CAUSE_NONE;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      wd_q      <= wd_d;
      cause_q   <= cause_d;
      if (rf_we && (rf_waddr != 5'd0)) gpr_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: ALU vector table plus hand sequences for
// wait states, branches/jumps, traps, watchdog and reset.
module tb_mips_mc_core;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        rst;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
  logic [1:0]  halt_cause;

  logic        w_rst;
  logic        w_mem_req, w_mem_we, w_mem_ack, w_halted;
  logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata, w_pc_dbg;
  logic [1:0]  w_halt_cause;

  mips_mc_core u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .halted     (halted),
    .halt_cause (halt_cause),
    .pc_dbg     (pc_dbg)
  );

  mips_mc_core #(.RESET_PC(32'h0000_3000), .MEM_TIMEOUT(4)) u_wd (
    .clk        (clk),
    .rst        (w_rst),
    .mem_req    (w_mem_req),
    .mem_we     (w_mem_we),
    .mem_addr   (w_mem_addr),
    .mem_wdata  (w_mem_wdata),
    .mem_rdata  (w_mem_rdata),
    .mem_ack    (w_mem_ack),
    .halted     (w_halted),
    .halt_cause (w_halt_cause),
    .pc_dbg     (w_pc_dbg)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          cyc;
  } txn_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sreg;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] mem [0:4095];
  txn_t        log_q[$];
  int          lat = 0;
  int          wait_cnt = 0;
  int          cyc = 0;
  int          ncmp = 0;
  int          nfail = 0;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  initial forever @(posedge clk) cyc++;

  // Memory model: ack after `lat` wait cycles, one transaction per ack.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      if (mem_req) begin
        if (wait_cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[13:2]];
          log_q.push_back('{addr: mem_addr, we: mem_we, wdata: mem_wdata, cyc: cyc});
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[13:2]] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    log_q.delete();
  endtask

  task automatic run_until_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic find_wr(input logic [31:0] a, output logic [31:0] d, output logic found);
    found = 1'b0;
    d     = '0;
    foreach (log_q[i])
      if (!found && log_q[i].we && log_q[i].addr == a) begin
        found = 1'b1;
        d     = log_q[i].wdata;
      end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        vecs[8];
    txn_t        dexp[7];
    logic [31:0] d;
    logic        found;
    int          lats[2];
    int          fifth[2];

    rst         = 1'b1;
    w_rst       = 1'b1;
    w_mem_ack   = 1'b0;
    w_mem_rdata = ILLEGAL;
    clear_mem();

    vecs[0] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h21), 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'h0000_0001};
    vecs[1] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h23), 32'h0000_0005, 32'h0000_0007, 5'd3, 32'hFFFF_FFFE};
    vecs[2] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 32'h0000_0001};
    vecs[3] = '{enc_r(5'd2, 5'd1, 5'd3, 6'h2A), 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 32'h0000_0000};
    vecs[4] = '{enc_i(6'h0D, 5'd1, 5'd3, 16'h8000), 32'h1234_0000, 32'h0, 5'd3, 32'h1234_8000};
    vecs[5] = '{enc_i(6'h09, 5'd1, 5'd3, 16'hFFFF), 32'h0000_0010, 32'h0, 5'd3, 32'h0000_000F};
    vecs[6] = '{enc_i(6'h0F, 5'd0, 5'd3, 16'hBEEF), 32'h0, 32'h0, 5'd3, 32'hBEEF_0000};
    vecs[7] = '{enc_r(5'd1, 5'd2, 5'd0, 6'h21), 32'h0000_0003, 32'h0000_0004, 5'd0, 32'h0000_0000};

    repeat (2) @(posedge clk);
    #1;
    check("reset halted", {31'd0, halted}, 32'd0);
    check("reset cause", {30'd0, halt_cause}, 32'd0);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset pc", pc_dbg, 32'h0000_3000);

    // ALU vector table: load operands, run one op, store the result to 0x100.
    for (int v = 0; v < 8; v++) begin
      clear_mem();
      put(32'h3000, enc_i(6'h0F, 5'd0, 5'd1, vecs[v].a[31:16]));
      put(32'h3004, enc_i(6'h0D, 5'd1, 5'd1, vecs[v].a[15:0]));
      put(32'h3008, enc_i(6'h0F, 5'd0, 5'd2, vecs[v].b[31:16]));
      put(32'h300C, enc_i(6'h0D, 5'd2, 5'd2, vecs[v].b[15:0]));
      put(32'h3010, vecs[v].instr);
      put(32'h3014, enc_i(6'h2B, 5'd0, vecs[v].sreg, 16'h0100));
      put(32'h3018, ILLEGAL);
      do_reset();
      run_until_halt($sformatf("vec%0d", v), 200);
      find_wr(32'h100, d, found);
      check($sformatf("vec%0d store seen", v), {31'd0, found}, 32'd1);
      check($sformatf("vec%0d result", v), d, vecs[v].exp);
      check($sformatf("vec%0d cause", v), {30'd0, halt_cause}, 32'd1);
    end

    // Test-plan program with zero and three wait states.
    lats[0] = 0;  fifth[0] = 17;
    lats[1] = 3;  fifth[1] = 38;
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'd5));
      put(32'h3004, enc_r(5'd1, 5'd1, 5'd2, 6'h21));
      put(32'h3008, enc_i(6'h2B, 5'd0, 5'd2, 16'd0));
      put(32'h300C, enc_i(6'h23, 5'd0, 5'd3, 16'd0));
      put(32'h3010, enc_i(6'h2B, 5'd0, 5'd3, 16'd4));
      put(32'h3014, ILLEGAL);
      lat = lats[k];
      do_reset();
      if (lats[k] == 3) begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check($sformatf("wait fetch req c%0d", i), {31'd0, mem_req}, 32'd1);
          check($sformatf("wait fetch addr c%0d", i), mem_addr, 32'h0000_3000);
        end
        @(negedge clk);
        check("wait req drops after ack", {31'd0, mem_req}, 32'd0);
      end
      run_until_halt($sformatf("prog lat%0d", lats[k]), 400);
      check($sformatf("prog lat%0d txns", lats[k]), 32'(log_q.size()), 32'd9);
      if (log_q.size() == 9) begin
        check($sformatf("prog lat%0d sw addr", lats[k]), log_q[3].addr, 32'h0);
        check($sformatf("prog lat%0d sw we", lats[k]), {31'd0, log_q[3].we}, 32'd1);
        check($sformatf("prog lat%0d sw $2", lats[k]), log_q[3].wdata, 32'd10);
        check($sformatf("prog lat%0d 5th fetch addr", lats[k]), log_q[6].addr, 32'h3010);
        check($sformatf("prog lat%0d 5th fetch cycle", lats[k]), 32'(log_q[6].cyc), 32'(fifth[k]));
        check($sformatf("prog lat%0d $3 value", lats[k]), log_q[7].wdata, 32'd10);
      end
      check($sformatf("prog lat%0d cause", lats[k]), {30'd0, halt_cause}, 32'd1);
    end
    lat = 0;

    // beq $0,$0,-1 loops on its own address every 3 cycles.
    clear_mem();
    put(32'h3000, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    do_reset();
    repeat (12) @(negedge clk);
    check("beq loop txns>=3", {31'd0, log_q.size() >= 3}, 32'd1);
    if (log_q.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        check($sformatf("beq fetch%0d addr", i), log_q[i].addr, 32'h3000);
        check($sformatf("beq fetch%0d cycle", i), 32'(log_q[i].cyc), 32'(3 * i));
      end
    check("beq loop not halted", {31'd0, halted}, 32'd0);

    // bne not taken, jal/jr round trip, $31 observed via store.
    clear_mem();
    put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'd1));
    put(32'h3004, enc_i(6'h05, 5'd1, 5'd1, 16'd5));
    put(32'h3008, enc_j(6'h03, 26'h000_0C08));
    put(32'h300C, enc_i(6'h2B, 5'd0, 5'd31, 16'h0104));
    put(32'h3010, ILLEGAL);
    put(32'h3020, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    dexp[0] = '{32'h3000, 1'b0, 32'h0, 0};
    dexp[1] = '{32'h3004, 1'b0, 32'h0, 4};
    dexp[2] = '{32'h3008, 1'b0, 32'h0, 7};
    dexp[3] = '{32'h3020, 1'b0, 32'h0, 10};
    dexp[4] = '{32'h300C, 1'b0, 32'h0, 13};
    dexp[5] = '{32'h0104, 1'b1, 32'h300C, 16};
    dexp[6] = '{32'h3010, 1'b0, 32'h0, 17};
    do_reset();
    run_until_halt("jump prog", 200);
    check("jump prog txns", 32'(log_q.size()), 32'd7);
    if (log_q.size() == 7)
      for (int i = 0; i < 7; i++) begin
        check($sformatf("jump txn%0d addr", i), log_q[i].addr, dexp[i].addr);
        check($sformatf("jump txn%0d we", i), {31'd0, log_q[i].we}, {31'd0, dexp[i].we});
        check($sformatf("jump txn%0d cycle", i), 32'(log_q[i].cyc), 32'(dexp[i].cyc));
        if (dexp[i].we) check($sformatf("jump txn%0d data", i), log_q[i].wdata, dexp[i].wdata);
      end

    // Misaligned lw: no data request, cause 10.
    clear_mem();
    put(32'h3000, enc_i(6'h23, 5'd0, 5'd3, 16'h0002));
    do_reset();
    run_until_halt("misaligned lw", 50);
    check("misaligned cause", {30'd0, halt_cause}, 32'd2);
    check("misaligned txns", 32'(log_q.size()), 32'd1);
    repeat (3) @(negedge clk);
    check("misaligned req idle", {31'd0, mem_req}, 32'd0);
    check("misaligned sticky", {31'd0, halted}, 32'd1);

    // Unsupported R-type funct.
    clear_mem();
    put(32'h3000, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    do_reset();
    run_until_halt("bad funct", 50);
    check("bad funct cause", {30'd0, halt_cause}, 32'd1);

    // Watchdog instance, limit 4: ack on the 4th request cycle wins.
    @(posedge clk);
    #1;
    w_rst = 1'b0;
    check("wd wdata reset", w_mem_wdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wd ackwin req c%0d", i), {31'd0, w_mem_req}, 32'd1);
      if (i == 3) w_mem_ack = 1'b1;
    end
    check("wd fetch is read", {31'd0, w_mem_we}, 32'd0);
    @(negedge clk);
    w_mem_ack = 1'b0;
    check("wd ackwin req drop", {31'd0, w_mem_req}, 32'd0);
    check("wd ackwin not halted", {31'd0, w_halted}, 32'd0);
    @(negedge clk);
    check("wd ackwin halted", {31'd0, w_halted}, 32'd1);
    check("wd ackwin cause", {30'd0, w_halt_cause}, 32'd1);

    // Ack never arrives: halt after 4 request cycles with cause 11.
    @(negedge clk);
    w_rst = 1'b1;
    @(posedge clk);
    #1;
    w_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wd timeout req c%0d", i), {31'd0, w_mem_req}, 32'd1);
      check($sformatf("wd timeout halted c%0d", i), {31'd0, w_halted}, 32'd0);
    end
    @(negedge clk);
    check("wd timeout halted", {31'd0, w_halted}, 32'd1);
    check("wd timeout cause", {30'd0, w_halt_cause}, 32'd3);
    check("wd timeout req off", {31'd0, w_mem_req}, 32'd0);
    w_rst = 1'b1;
    @(posedge clk);
    #1;
    check("wd rst halted", {31'd0, w_halted}, 32'd0);
    check("wd rst cause", {30'd0, w_halt_cause}, 32'd0);
    check("wd rst pc", w_pc_dbg, 32'h0000_3000);
    w_rst = 1'b0;
    @(negedge clk);
    check("wd restart req", {31'd0, w_mem_req}, 32'd1);
    check("wd restart addr", w_mem_addr, 32'h0000_3000);
    w_rst = 1'b1;
    #1;
    check("wd rst mid-request drop", {31'd0, w_mem_req}, 32'd0);
    @(posedge clk);
    #1;
    w_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
# mips_mc_core

Parametrised multicycle MIPS-Lite core with one shared instruction/data memory port using a req/ack handshake, so memory may take any number of wait states. The register file, ALU, instruction register and the A, B, ALUOut and MDR holding registers are internal. The core adds behaviour the fixed-latency datapath lacks: variable memory latency, a configurable reset vector, a memory-timeout watchdog, and a sticky halt for illegal opcodes and misaligned accesses. It is the CPU node of the system; the memory/bus model connects to the `mem_*` port.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `MEM_TIMEOUT`, 256: maximum cycles a request may wait for ack; 0 disables the watchdog.

Ports:
- `clk`, in, 1: clock; every state element is updated on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `mem_req`, out, 1: memory request valid.
- `mem_we`, out, 1: 1 = store word, 0 = load word or instruction fetch.
- `mem_addr`, out, 32: byte address, always word-aligned.
- `mem_wdata`, out, 32: store data (B register).
- `mem_rdata`, in, 32: read data, valid in the ack cycle.
- `mem_ack`, in, 1: transaction complete when sampled high with `mem_req` high.
- `halted`, out, 1: core stopped; sticky until `rst`.
- `halt_cause`, out, 2: 00 none, 01 illegal opcode/funct, 10 misaligned lw/sw, 11 memory timeout.
- `pc_dbg`, out, 32: current PC.

## Operation
- Instruction set: addu, subu, slt, jr (R-type); ori, lui, addiu, lw, sw, beq, bne, j, jal. Any other opcode or R-type funct raises halt cause 01. No overflow traps.
- GPR $0 reads 0; writes to $0 are discarded. jal writes PC+4 to $31.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On ack: IR <= `mem_rdata`, PC <= PC+4, go to DECODE.
- DECODE: A, B <= rs, rt. ALUOut <= PC + (sext(imm)<<2). Illegal instruction goes to HALT.
- EXEC:
  - beq/bne: PC <= ALUOut if the condition holds, then FETCH.
  - j: PC <= {PC[31:28], target, 00}, then FETCH.
  - jal: same PC update, $31 <= PC, then FETCH.
  - jr: PC <= A, then FETCH.
  - ALU ops: ALUOut <= result, then WB.
  - lw/sw: ALUOut <= A + sext(imm). If the address bits [1:0] are nonzero, go to HALT with cause 10; otherwise go to MEM.
- Immediate extension: ori zero-extends imm; addiu, lw, sw and branches sign-extend it. lui result is {imm, 16'h0}.
- MEM: `mem_req`=1, `mem_addr`=ALUOut, `mem_we`=1 for sw. On ack: sw goes to FETCH; lw sets MDR <= `mem_rdata` and goes to WB.
- WB: rd for R-type, rt for immediate ops, rt <= MDR for lw; then FETCH.
- HALT: `mem_req`=0, `halted`=1. The state is held until `rst`; `halt_cause` is set on entry.
- Watchdog: a counter clears on entry to FETCH or MEM and increments every cycle `mem_req`=1 without ack. When it reaches `MEM_TIMEOUT` the core goes to HALT with cause 11 and drops `mem_req`.

## Timing
- Reset values while `rst` is high: state FETCH, PC=`RESET_PC`, IR/A/B/ALUOut/MDR=0, all GPRs 0, `halted`=0, `halt_cause`=00. `mem_req` is forced to 0.
- The first fetch request is in the first cycle after `rst` falls.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state only and are stable for the whole request.
- `mem_req` deasserts in the cycle after ack. `mem_ack` with `mem_req`=0 is ignored.
- Cycle counts with zero wait states (ack in the same cycle as req):
  - branch, j, jal, jr: 3
  - sw, R-type, immediate: 4
  - lw: 5
- Each wait cycle adds 1 to these counts.
- Reset asserted mid-request: the request drops in the same cycle and the transaction is abandoned.
- Ack in the same cycle the watchdog reaches its limit: the ack wins.
- PC increment wraps modulo 2^32.

## Structure
- Package `mips_mc_pkg` holds: opcode and funct localparams, the state enum, halt-cause codes, and the ALU op enum.
- Sub-module `mips_mc_alu` is combinational: add, sub, or, slt, lui, with a zero flag.
- The register file is inline: 32x32, two combinational read ports, one write port.

## Test plan
- Zero-wait program `ori $1,$0,5; addu $2,$1,$1; sw $2,0($0); lw $3,0($0)` -> $3=10; total cycles 4+4+4+5=17 after reset.
- Fetch with ack delayed 3 cycles -> `mem_req` and `mem_addr` held stable for 4 cycles; IR loads on the ack edge.
- `beq` taken with imm=-1 -> next fetch address equals the branch's own address. `bne` not taken -> next fetch at PC+4.
- `jal` at 0x3008 -> $31=0x300C and the next fetch is at the jump target. `jr $31` returns to 0x300C.
- `lw` to address 0x2 -> no MEM request, `halted`=1, `halt_cause`=10. Illegal opcode 6'h3F -> cause 01.
- With `MEM_TIMEOUT`=4 and ack never arriving -> `halted` rises after 4 request cycles with cause 11. `rst` then restarts fetching at `RESET_PC`.
